// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the five-stage RISC-V core.
// Provides the architectural width, the canonical NOP encoding, the
// fetch-stage state type and the IF/ID payload struct that decode
// consumes directly.
package pipe_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        valid: 1'b0,
        inst:  NOP_INST,
        pc:    '0,
        pc4:   '0
    };

endpackage : pipe_pkg

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (resets to a bubble)
//   hold        - keep the current contents
//   bubble      - load a bubble; takes priority over hold
//   d           - next IF/ID payload when neither hold nor bubble
//   q           - registered IF/ID payload
module if_id_reg
    import pipe_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   hold,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= IF_ID_BUBBLE;
        end else if (bubble) begin
            q <= IF_ID_BUBBLE;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule : if_id_reg

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the I-cache read port and
// fills the IF/ID register. Handles cache-miss stalls, decode load-use
// stalls and redirects, including redirects that arrive mid-miss (the
// target is parked in a pending register until the cache releases).
// Ports:
//   clk, rst_n               - clock, asynchronous active-low reset
//   icache_ren/wen/addr/wdata - I-cache request (write side tied off)
//   icache_stall, icache_rdata - I-cache response
//   hazard_stall             - freeze PC and IF/ID (load-use from decode)
//   redirect_valid/pc        - taken branch/jump target
//   if_id_*                  - IF/ID pipeline register outputs
module if_stage
    import pipe_pkg::*;
#(
    parameter bit              SWAP_BYTES = 1'b1,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            icache_ren,
    output logic            icache_wen,
    output logic [29:0]     icache_addr,
    output logic [31:0]     icache_wdata,
    input  logic            icache_stall,
    input  logic [31:0]     icache_rdata,
    input  logic            hazard_stall,
    input  logic            redirect_valid,
    input  logic [31:0]     redirect_pc,
    output logic            if_id_valid,
    output logic [31:0]     if_id_inst,
    output logic [31:0]     if_id_pc,
    output logic [31:0]     if_id_pc4
);

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pending;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] inst;
    logic            ifid_hold;
    logic            ifid_bubble;
    if_id_t          ifid_d;
    if_id_t          ifid_q;

    assign target       = {redirect_pc[31:2], 2'b00};
    assign icache_addr  = pc[31:2];
    assign icache_wen   = 1'b0;
    assign icache_wdata = '0;

    if (SWAP_BYTES) begin : g_swap
        assign inst = {icache_rdata[7:0], icache_rdata[15:8],
                       icache_rdata[23:16], icache_rdata[31:24]};
    end else begin : g_noswap
        assign inst = icache_rdata;
    end

    // PC, pending target and fetch FSM. While in DRAIN the cache still
    // holds the old address, so the PC must not move until the stall
    // clears; the latest redirect seen wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            pending    <= '0;
            icache_ren <= 1'b0;
        end else begin
            icache_ren <= 1'b1;
            case (state)
                FETCH: begin
                    if (redirect_valid) begin
                        if (icache_stall) begin
                            pending <= target;
                            state   <= DRAIN;
                        end else begin
                            pc <= target;
                        end
                    end else if (!icache_stall && !hazard_stall) begin
                        pc <= pc + 32'd4;
                    end
                end
                DRAIN: begin
                    if (redirect_valid) begin
                        pending <= target;
                    end
                    if (!icache_stall) begin
                        pc    <= redirect_valid ? target : pending;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    // IF/ID control. A miss with a concurrent load-use stall must keep the
    // instruction decode is waiting on, so hold wins over bubble there.
    always_comb begin
        ifid_hold   = 1'b0;
        ifid_bubble = 1'b0;
        if (state == DRAIN || redirect_valid) begin
            ifid_bubble = 1'b1;
        end else if (icache_stall) begin
            if (hazard_stall) ifid_hold = 1'b1;
            else              ifid_bubble = 1'b1;
        end else if (hazard_stall) begin
            ifid_hold = 1'b1;
        end
    end

    assign ifid_d = '{valid: 1'b1, inst: inst, pc: pc, pc4: pc + 32'd4};

    if_id_reg u_if_id_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (ifid_hold),
        .bubble (ifid_bubble),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    assign if_id_valid = ifid_q.valid;
    assign if_id_inst  = ifid_q.inst;
    assign if_id_pc    = ifid_q.pc;
    assign if_id_pc4   = ifid_q.pc4;

endmodule : if_stage
